// File: rtl/time_display_if.sv
// time_display_if
// Bundles the time-display signals between the time-bus producer and
// time_display_driver.
//   data_in    : {hours, minutes, seconds}, one binary byte per field
//   blank      : 1 = all anodes off
//   blink_mask : bit0 = seconds, bit1 = minutes, bit2 = hours
//   an         : digit anodes, active-low, at most one low
//   seg        : {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
//   busy       : BCD conversion in progress
//   conv_done  : one-cycle pulse when new digits are committed
//   range_err  : a field of the last converted word was above 99
// Modport master drives the inputs (producer / bench).
// Modport slave is the driver side.
interface time_display_if;
    logic [23:0] data_in;
    logic        blank;
    logic [2:0]  blink_mask;
    logic [5:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        busy;
    logic        conv_done;
    logic        range_err;

    modport master (
        output data_in, blank, blink_mask,
        input  an, seg, dp, busy, conv_done, range_err
    );

    modport slave (
        input  data_in, blank, blink_mask,
        output an, seg, dp, busy, conv_done, range_err
    );
endinterface

// File: rtl/time_display_driver.sv
// time_display_driver
// Converts the packed binary time word to BCD with a sequential
// double-dabble engine. The engine runs 8 iterations, with all three fields
// processed in parallel. The driver scans the six digits of a common-anode
// 7-segment display.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-low reset
//   bus   : time_display_if.slave (data_in, blank, blink_mask in;
//           an, seg, dp, busy, conv_done, range_err out)
// Parameters:
//   SCAN_DIV  : clocks per digit slot (>= 2)
//   BLINK_DIV : clocks per blink half-period (>= 2)
module time_display_driver #(
    parameter int SCAN_DIV  = 8333,
    parameter int BLINK_DIV = 25000000
) (
    input  logic           clock,
    input  logic           reset,
    time_display_if.slave  bus
);

    localparam int SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CONV = 1'b1;

    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Shift register layout: [19:16] hundreds, [15:12] tens,
    // [11:8] ones, [7:0] binary bits that are still to be shifted in.
    // The function does one double-dabble iteration.
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = SEG_DASH;
        endcase
    endfunction

    logic [0:0]        state_r;
    logic [2:0]        cnt_r;
    logic [23:0]       last_word_r;
    logic [2:0][19:0]  sh_r;
    logic [2:0][19:0]  step_s;
    logic [2:0][11:0]  bcd_r;        // per field {hundreds, tens, ones}
    logic              busy_r;
    logic              conv_done_r;
    logic              range_err_r;

    logic [SCAN_W-1:0]  scan_cnt_r;
    logic [2:0]         idx_r;
    logic [BLINK_W-1:0] blink_cnt_r;
    logic               phase_r;

    logic [5:0] an_r;
    logic [6:0] seg_r;
    logic       dp_r;

    logic [1:0] field_s;
    logic [3:0] digit_s;
    logic       hide_s;
    logic [5:0] an_s;
    logic [6:0] seg_s;
    logic       dp_s;

    // One double-dabble iteration for each of the three fields.
    always_comb begin
        for (int f = 0; f < 3; f++) begin
            step_s[f] = dd_step(sh_r[f]);
        end
    end

    // Converter FSM. IDLE captures a changed word. CONV iterates 8 times,
    // then commits the digits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 3'd0;
            last_word_r <= 24'hFFFFFF;
            sh_r        <= '0;
            bcd_r       <= '0;
            busy_r      <= 1'b0;
            conv_done_r <= 1'b0;
            range_err_r <= 1'b0;
        end else begin
            conv_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.data_in != last_word_r) begin
                        last_word_r <= bus.data_in;
                        sh_r[0]     <= {12'd0, bus.data_in[7:0]};
                        sh_r[1]     <= {12'd0, bus.data_in[15:8]};
                        sh_r[2]     <= {12'd0, bus.data_in[23:16]};
                        cnt_r       <= 3'd0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_CONV;
                    end else begin
                        busy_r      <= 1'b0;
                    end
                end
                ST_CONV: begin
                    sh_r  <= step_s;
                    cnt_r <= cnt_r + 3'd1;
                    if (cnt_r == 3'd7) begin
                        bcd_r[0]    <= step_s[0][19:8];
                        bcd_r[1]    <= step_s[1][19:8];
                        bcd_r[2]    <= step_s[2][19:8];
                        range_err_r <= (step_s[0][19:16] != 4'd0) ||
                                       (step_s[1][19:16] != 4'd0) ||
                                       (step_s[2][19:16] != 4'd0);
                        conv_done_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        busy_r      <= 1'b1;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Digit-slot timer. The digit index advances on each wrap, 0..5.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scan_cnt_r <= '0;
            idx_r      <= 3'd0;
        end else if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r <= '0;
            idx_r      <= (idx_r == 3'd5) ? 3'd0 : idx_r + 3'd1;
        end else begin
            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
        end
    end

    // Blink phase timer. The phase toggles once every BLINK_DIV clocks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_cnt_r <= '0;
            phase_r     <= 1'b0;
        end else if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= '0;
            phase_r     <= ~phase_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
        end
    end

    // Selects the field and digit for the current slot, then works out the
    // next an/seg/dp values.
    always_comb begin
        field_s = 2'd0;
        digit_s = 4'd0;
        case (idx_r)
            3'd0:    begin field_s = 2'd0; digit_s = bcd_r[0][3:0]; end
            3'd1:    begin field_s = 2'd0; digit_s = bcd_r[0][7:4]; end
            3'd2:    begin field_s = 2'd1; digit_s = bcd_r[1][3:0]; end
            3'd3:    begin field_s = 2'd1; digit_s = bcd_r[1][7:4]; end
            3'd4:    begin field_s = 2'd2; digit_s = bcd_r[2][3:0]; end
            3'd5:    begin field_s = 2'd2; digit_s = bcd_r[2][7:4]; end
            default: begin field_s = 2'd0; digit_s = 4'd0;          end
        endcase

        hide_s = bus.blank || (phase_r && bus.blink_mask[field_s]);

        if (hide_s) begin
            an_s = 6'b111111;
            dp_s = 1'b1;
        end else begin
            an_s = ~(6'b000001 << idx_r);
            dp_s = !((idx_r == 3'd2) || (idx_r == 3'd4));
        end

        // Any nonzero hundreds digit means the field is out of range;
        // both digits of that field show a dash.
        if (bcd_r[field_s][11:8] != 4'd0) begin
            seg_s = SEG_DASH;
        end else begin
            seg_s = seg_of(digit_s);
        end
    end

    // Registered display outputs, one clock behind the index and the digits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            an_r  <= 6'b111111;
            seg_r <= 7'b1111111;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_s;
            seg_r <= seg_s;
            dp_r  <= dp_s;
        end
    end

    assign bus.an        = an_r;
    assign bus.seg       = seg_r;
    assign bus.dp        = dp_r;
    assign bus.busy      = busy_r;
    assign bus.conv_done = conv_done_r;
    assign bus.range_err = range_err_r;

endmodule

// File: tb/tb_time_display_driver.sv
module tb_time_display_driver;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    time_display_if tif();

    time_display_driver #(.SCAN_DIV(4), .BLINK_DIV(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (tif)
    );

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;

    int n_cmp = 0;
    int n_bad = 0;
    int k;                      // clock edges since reset release
    logic [6:0] exp_seg [6];    // expected seg per digit index

    always @(posedge clock or negedge reset) begin
        if (!reset) k <= 0;
        else        k <= k + 1;
    end

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic set_exp(input logic [6:0] d0, input logic [6:0] d1, input logic [6:0] d2,
                           input logic [6:0] d3, input logic [6:0] d4, input logic [6:0] d5);
        exp_seg[0] = d0; exp_seg[1] = d1; exp_seg[2] = d2;
        exp_seg[3] = d3; exp_seg[4] = d4; exp_seg[5] = d5;
    endtask

    // Scan/blink reference: the outputs after edge k reflect the index and
    // phase after edge k-1.
    task automatic model_run(input string tag, input int n);
        int kk, idx, ph;
        logic hide;
        logic [5:0] e_an;
        logic e_dp;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            kk   = k - 1;
            idx  = (kk / 4) % 6;
            ph   = (kk / 64) % 2;
            hide = tif.blank || ((ph == 1) && tif.blink_mask[idx / 2]);
            e_an = hide ? 6'b111111 : ~(6'b000001 << idx);
            e_dp = hide ? 1'b1 : ((idx == 2 || idx == 4) ? 1'b0 : 1'b1);
            chk({tag, "_an"}, {18'd0, tif.an}, {18'd0, e_an});
            chk({tag, "_dp"}, {23'd0, tif.dp}, {23'd0, e_dp});
            if (!hide) chk({tag, "_seg"}, {17'd0, tif.seg}, {17'd0, exp_seg[idx]});
        end
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        logic got;
        got = 1'b0;
        for (int i = 0; i < max_cycles && !got; i++) begin
            @(negedge clock);
            if (tif.conv_done) got = 1'b1;
        end
        chk(tag, {23'd0, got}, 24'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] t3_seg [6];
        int idx;

        tif.data_in    = 24'h173B05;
        tif.blank      = 1'b0;
        tif.blink_mask = 3'b000;

        // reset values
        step(2);
        chk("rst_an",   {18'd0, tif.an},  24'h3F);
        chk("rst_seg",  {17'd0, tif.seg}, 24'h7F);
        chk("rst_dp",   {23'd0, tif.dp},        24'd1);
        chk("rst_busy", {23'd0, tif.busy},      24'd0);
        chk("rst_done", {23'd0, tif.conv_done}, 24'd0);
        chk("rst_rerr", {23'd0, tif.range_err}, 24'd0);

        // Test 1: first conversion after release, 23:59:05
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("t1_busy", {23'd0, tif.busy}, 24'd1);
        end
        @(negedge clock);
        chk("t1_done",   {23'd0, tif.conv_done}, 24'd1);
        chk("t1_idle",   {23'd0, tif.busy},      24'd0);
        chk("t1_rerr",   {23'd0, tif.range_err}, 24'd0);
        @(negedge clock);
        chk("t1_pulse",  {23'd0, tif.conv_done}, 24'd0);

        // Test 2: scan walk and separators with steady data
        set_exp(S5, S0, S9, S5, S3, S2);
        model_run("t2_scan", 30);

        // Test 3: a change during CONV is deferred, not lost
        tif.data_in = 24'h0C222D;     // 12:34:45
        step(1);
        chk("t3_busy", {23'd0, tif.busy}, 24'd1);
        step(3);
        tif.data_in = 24'h000001;
        step(5);
        chk("t3_done1", {23'd0, tif.conv_done}, 24'd1);
        step(1);
        chk("t3_pulse",  {23'd0, tif.conv_done}, 24'd0);
        chk("t3_busy2",  {23'd0, tif.busy},      24'd1);
        t3_seg[0] = S5; t3_seg[1] = S4; t3_seg[2] = S4;
        t3_seg[3] = S3; t3_seg[4] = S2; t3_seg[5] = S1;
        idx = ((k - 1) / 4) % 6;
        chk("t3_first_seg", {17'd0, tif.seg}, {17'd0, t3_seg[idx]});
        step(7);
        chk("t3_not_yet", {23'd0, tif.conv_done}, 24'd0);
        step(1);
        chk("t3_done2",   {23'd0, tif.conv_done}, 24'd1);
        step(1);
        set_exp(S1, S0, S0, S0, S0, S0);
        model_run("t3_digits", 24);

        // Test 4: out-of-range seconds, then recovery
        tif.data_in = 24'h0000C8;     // seconds = 200
        wait_done("t4_done", 20);
        chk("t4_rerr", {23'd0, tif.range_err}, 24'd1);
        step(1);
        set_exp(SD, SD, S0, S0, S0, S0);
        model_run("t4_dash", 24);
        tif.data_in = 24'h000007;
        step(8);
        chk("t4_rerr_hold", {23'd0, tif.range_err}, 24'd1);
        chk("t4_done_low",  {23'd0, tif.conv_done}, 24'd0);
        step(1);
        chk("t4_rerr_clr",  {23'd0, tif.range_err}, 24'd0);
        chk("t4_done2",     {23'd0, tif.conv_done}, 24'd1);
        step(1);
        set_exp(S7, S0, S0, S0, S0, S0);
        model_run("t4_ok", 24);

        // Test 5: minutes blink, then global blank
        tif.blink_mask = 3'b010;
        model_run("t5_blink", 160);
        tif.blank = 1'b1;
        step(1);
        chk("t5_blank_an", {18'd0, tif.an}, 24'h3F);
        chk("t5_blank_dp", {23'd0, tif.dp}, 24'd1);
        model_run("t5_blank", 12);
        tif.blank      = 1'b0;
        tif.blink_mask = 3'b000;
        step(1);
        model_run("t5_unblank", 12);

        // Test 6: reset during CONV cycle 4
        tif.data_in = 24'h173B05;
        step(5);
        #1 reset = 1'b0;
        #1;
        chk("t6_an",   {18'd0, tif.an},  24'h3F);
        chk("t6_seg",  {17'd0, tif.seg}, 24'h7F);
        chk("t6_dp",   {23'd0, tif.dp},        24'd1);
        chk("t6_busy", {23'd0, tif.busy},      24'd0);
        chk("t6_done", {23'd0, tif.conv_done}, 24'd0);
        chk("t6_rerr", {23'd0, tif.range_err}, 24'd0);
        step(2);
        reset = 1'b1;
        step(1);
        chk("t6_busy_start", {23'd0, tif.busy}, 24'd1);
        step(7);
        chk("t6_busy_end",   {23'd0, tif.busy},      24'd1);
        chk("t6_not_done",   {23'd0, tif.conv_done}, 24'd0);
        step(1);
        chk("t6_done_pulse", {23'd0, tif.conv_done}, 24'd1);
        chk("t6_rerr_ok",    {23'd0, tif.range_err}, 24'd0);
        step(1);
        set_exp(S5, S0, S9, S5, S3, S2);
        model_run("t6_digits", 24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
